// File: rtl/residual_add_relu_sync_if.sv
// Pixel bus for the residual join stage.
//   master: drives the main/skip pixel streams, observes the result stream.
//   slave : the residual_add_relu_sync block.
interface residual_add_relu_sync_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid_main;
  logic [DATA_WIDTH-1:0] pxl_main;
  logic                  valid_skip;
  logic [DATA_WIDTH-1:0] pxl_skip;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_out;
  logic                  frame_done;
  logic                  overflow;

  modport master (
    output valid_main, pxl_main, valid_skip, pxl_skip,
    input  pxl_out, valid_out, frame_done, overflow
  );

  modport slave (
    input  valid_main, pxl_main, valid_skip, pxl_skip,
    output pxl_out, valid_out, frame_done, overflow
  );
endinterface

// File: rtl/residual_add_relu_sync.sv
// Residual join for a bottleneck block: aligns main and shortcut streams with
// two FIFOs, adds paired pixels in FP32 and applies ReLU.
//   clk, reset : clock, asynchronous active-high reset
//   bus (slave): valid_main/pxl_main, valid_skip/pxl_skip in;
//                pxl_out/valid_out, frame_done pulse, sticky overflow out.
// The adder is single precision, so DATA_WIDTH must stay 32.

// Synchronous FIFO, not first-word-fall-through: rd_data_c shows the head word,
// which the reader registers on the same edge it pops.
module residual_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             empty_c,
  output logic             full_c
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en;

  // Full is judged on the registered count, so a concurrent pop never frees a slot early.
  assign full_c    = (count == CW'(DEPTH));
  assign empty_c   = (count == '0);
  assign wr_en     = wr_valid && !full_c;
  assign rd_data_c = mem[rd_ptr];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// FP32 add/subtract, round-to-nearest-even, one register stage.
module fp_add_sub (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        op_sub,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        valid_out,
  output logic [31:0] out
);
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, res;
    logic        eff_sub, sticky, rup;
    logic [7:0]  ex_f, ey_f;
    logic [8:0]  ex, ey, d, lim, sh, e, e_out;
    logic [4:0]  sh_r, lz;
    logic [26:0] mx, my, my_sh, lost_mask, norm;
    logic [27:0] sum;
    logic [24:0] rnd;
    logic [22:0] mant;
    // Order operands by magnitude so the alignment shift is never negative.
    x       = (a[30:0] >= b[30:0]) ? a : b;
    y       = (a[30:0] >= b[30:0]) ? b : a;
    eff_sub = x[31] ^ y[31];
    ex_f    = x[30:23];
    ey_f    = y[30:23];
    ex      = (ex_f == 8'd0) ? 9'd1 : {1'b0, ex_f};
    ey      = (ey_f == 8'd0) ? 9'd1 : {1'b0, ey_f};
    mx      = {(ex_f != 8'd0), x[22:0], 3'b000};
    my      = {(ey_f != 8'd0), y[22:0], 3'b000};
    // Align the smaller operand; bits shifted out collapse into the sticky bit.
    d         = ex - ey;
    sh_r      = (d > 9'd26) ? 5'd27 : d[4:0];
    lost_mask = ~(27'h7FFFFFF << sh_r);
    sticky    = |(my & lost_mask);
    my_sh     = (my >> sh_r) | {26'd0, sticky};
    sum       = eff_sub ? ({1'b0, mx} - {1'b0, my_sh}) : ({1'b0, mx} + {1'b0, my_sh});
    // Normalise: carry-out shifts right, cancellation shifts left down to the subnormal floor.
    lz = 5'd27;
    for (int i = 0; i <= 26; i++) if (sum[i]) lz = 5'(26 - i);
    lim = ex - 9'd1;
    sh  = ({4'd0, lz} > lim) ? lim : {4'd0, lz};
    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e    = ex + 9'd1;
    end else begin
      norm = sum[26:0] << sh;
      e    = ex - sh;
    end
    rup = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[26:3]} + 25'(rup);
    if (rnd[24]) begin
      e_out = e + 9'd1;
      mant  = 23'd0;
    end else begin
      e_out = rnd[23] ? e : 9'd0;
      mant  = rnd[22:0];
    end
    if (e_out >= 9'd255) res = {x[31], 8'hFF, 23'd0};
    else                 res = {x[31], e_out[7:0], mant};
    if (sum == 28'd0) res = {x[31] & y[31], 31'd0};
    // Infinity and NaN operands bypass the datapath.
    if (ex_f == 8'hFF || ey_f == 8'hFF) begin
      if ((ex_f == 8'hFF && x[22:0] != 23'd0) || (ey_f == 8'hFF && y[22:0] != 23'd0))
        res = 32'h7FC00000;
      else if (ex_f == 8'hFF && ey_f == 8'hFF && eff_sub)
        res = 32'h7FC00000;
      else
        res = x;
    end
    return res;
  endfunction

  logic [31:0] sum_c;

  always_comb begin
    sum_c = fp_add(in_a, {in_b[31] ^ op_sub, in_b[30:0]});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      out       <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) out <= sum_c;
    end
  end
endmodule

module residual_add_relu_sync #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned IMAGE_WIDTH  = 64,
  parameter int unsigned IMAGE_HEIGHT = 64,
  parameter int unsigned CHANNEL_NUM  = 1024,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned FRAME_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM
) (
  input  logic                     clk,
  input  logic                     reset,
  residual_add_relu_sync_if.slave  bus
);
  localparam int unsigned CNT_W = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;

  logic [DATA_WIDTH-1:0] main_head_c, skip_head_c;
  logic                  main_empty_c, skip_empty_c, main_full_c, skip_full_c;
  logic                  pop_c;
  logic [DATA_WIDTH-1:0] pair_main, pair_skip;
  logic                  pair_valid;
  logic [DATA_WIDTH-1:0] add_sum;
  logic                  add_valid;
  logic [CNT_W-1:0]      pix_cnt;
  logic                  last_c;
  logic [DATA_WIDTH-1:0] pxl_out_q;
  logic                  valid_out_q, frame_done_q, overflow_q;

  residual_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo_main (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (bus.valid_main),
    .wr_data   (bus.pxl_main),
    .rd_en     (pop_c),
    .rd_data_c (main_head_c),
    .empty_c   (main_empty_c),
    .full_c    (main_full_c)
  );

  residual_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo_skip (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (bus.valid_skip),
    .wr_data   (bus.pxl_skip),
    .rd_en     (pop_c),
    .rd_data_c (skip_head_c),
    .empty_c   (skip_empty_c),
    .full_c    (skip_full_c)
  );

  // A pair issues whenever both branches have a word waiting.
  assign pop_c = !main_empty_c && !skip_empty_c;

  // Pair register feeding the adder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_valid <= 1'b0;
      pair_main  <= '0;
      pair_skip  <= '0;
    end else begin
      pair_valid <= pop_c;
      if (pop_c) begin
        pair_main <= main_head_c;
        pair_skip <= skip_head_c;
      end
    end
  end

  // Sticky overflow: any strobe that meets a full FIFO loses its word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else if ((bus.valid_main && main_full_c) || (bus.valid_skip && skip_full_c))
      overflow_q <= 1'b1;
  end

  fp_add_sub u_add (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (pair_valid),
    .op_sub    (1'b0),
    .in_a      (pair_main),
    .in_b      (pair_skip),
    .valid_out (add_valid),
    .out       (add_sum)
  );

  assign last_c = (pix_cnt == CNT_W'(FRAME_SIZE - 1));

  // ReLU register and frame pixel counter; any sign-set sum becomes +0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pxl_out_q    <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pix_cnt      <= '0;
    end else begin
      valid_out_q  <= add_valid;
      frame_done_q <= add_valid && last_c;
      if (add_valid) begin
        pxl_out_q <= add_sum[DATA_WIDTH-1] ? '0 : add_sum;
        pix_cnt   <= last_c ? '0 : pix_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pxl_out    = pxl_out_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_residual_add_relu_sync.sv
// Bench for residual_add_relu_sync: DUT A (FIFO_DEPTH 16) covers latency, clamp,
// skew, throughput, frame boundaries and reset mid-stream; DUT B (FIFO_DEPTH 4)
// covers overflow. Both use an 8-pixel frame (2x2x2).
module tb_residual_add_relu_sync;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] exp_a, exp_b;
  int          cnt_a = 0, cnt_b = 0, run_a = 0, max_run_a = 0;
  int          lat;

  always #5 clk = ~clk;

  residual_add_relu_sync_if #(.DATA_WIDTH(32)) bus_a ();
  residual_add_relu_sync_if #(.DATA_WIDTH(32)) bus_b ();

  residual_add_relu_sync #(
    .DATA_WIDTH(32), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .CHANNEL_NUM(2), .FIFO_DEPTH(16)
  ) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));

  residual_add_relu_sync #(
    .DATA_WIDTH(32), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .CHANNEL_NUM(2), .FIFO_DEPTH(4)
  ) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Exact FP32 encoding of a small positive integer.
  function automatic logic [31:0] fbits(input int n);
    int p;
    p = 0;
    for (int i = 0; i < 31; i++) if (n[i]) p = i;
    return {1'b0, 8'(127 + p), 23'(n << (23 - p))};
  endfunction

  task automatic drive_a(input logic vm, input logic [31:0] m, input logic vs, input logic [31:0] s);
    bus_a.valid_main = vm; bus_a.pxl_main = m; bus_a.valid_skip = vs; bus_a.pxl_skip = s;
    @(posedge clk); #1;
  endtask

  task automatic drive_b(input logic vm, input logic [31:0] m, input logic vs, input logic [31:0] s);
    bus_b.valid_main = vm; bus_b.pxl_main = m; bus_b.valid_skip = vs; bus_b.pxl_skip = s;
    @(posedge clk); #1;
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) drive_a(1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic idle_b(input int n);
    for (int i = 0; i < n; i++) drive_b(1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic drain_a();
    for (int k = 0; k < 50 && qa.size() != 0; k++) idle_a(1);
    check("a_drain", 32'(qa.size()), 32'd0);
  endtask

  task automatic drain_b();
    for (int k = 0; k < 50 && qb.size() != 0; k++) idle_b(1);
    check("b_drain", 32'(qb.size()), 32'd0);
  endtask

  // Scoreboard A: output order, value and frame_done position.
  always @(negedge clk) begin
    if (rst_a) begin
      qa.delete();
      cnt_a = 0;
      run_a = 0;
    end else if (bus_a.valid_out) begin
      if (qa.size() == 0) check("a_spurious_valid", 32'(bus_a.valid_out), 32'd0);
      else begin
        exp_a = qa.pop_front();
        check("a_pxl_out", bus_a.pxl_out, exp_a);
        check("a_frame_done", 32'(bus_a.frame_done), 32'(cnt_a % 8 == 7));
      end
      cnt_a++;
      run_a++;
      if (run_a > max_run_a) max_run_a = run_a;
    end else begin
      run_a = 0;
      check("a_frame_done_idle", 32'(bus_a.frame_done), 32'd0);
    end
  end

  // Scoreboard B.
  always @(negedge clk) begin
    if (rst_b) begin
      qb.delete();
      cnt_b = 0;
    end else if (bus_b.valid_out) begin
      if (qb.size() == 0) check("b_spurious_valid", 32'(bus_b.valid_out), 32'd0);
      else begin
        exp_b = qb.pop_front();
        check("b_pxl_out", bus_b.pxl_out, exp_b);
        check("b_frame_done", 32'(bus_b.frame_done), 32'(cnt_b % 8 == 7));
      end
      cnt_b++;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus_a.valid_main = 1'b0; bus_a.pxl_main = '0; bus_a.valid_skip = 1'b0; bus_a.pxl_skip = '0;
    bus_b.valid_main = 1'b0; bus_b.pxl_main = '0; bus_b.valid_skip = 1'b0; bus_b.pxl_skip = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pxl_out", bus_a.pxl_out, 32'd0);
    check("rst_valid_out", 32'(bus_a.valid_out), 32'd0);
    check("rst_frame_done", 32'(bus_a.frame_done), 32'd0);
    check("rst_overflow", 32'(bus_a.overflow), 32'd0);
    check("rst_b_overflow", 32'(bus_b.overflow), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle_a(2);

    // Aligned pair: 1.5 + 2.0, latency measured from the write edge.
    qa.push_back(32'h40600000);
    drive_a(1'b1, 32'h3FC00000, 1'b1, 32'h40000000);
    for (lat = 0; lat < 10 && !bus_a.valid_out; lat++) idle_a(1);
    check("a_latency", 32'(lat), 32'd3);
    drain_a();
    idle_a(3);
    check("a_idle_hold", bus_a.pxl_out, 32'h40600000);

    // Negative clamp and signed zero.
    qa.push_back(32'h00000000);
    drive_a(1'b1, 32'hC0400000, 1'b1, 32'h3F800000);
    qa.push_back(32'h00000000);
    drive_a(1'b1, 32'h80000000, 1'b1, 32'h00000000);
    drain_a();

    // Skip leads by 10: skip 1..10, then main 1.0 x10 -> 2..11.
    for (int k = 1; k <= 10; k++) drive_a(1'b0, 32'd0, 1'b1, fbits(k));
    for (int k = 1; k <= 10; k++) begin
      qa.push_back(fbits(k + 1));
      drive_a(1'b1, fbits(1), 1'b0, 32'd0);
    end
    drain_a();
    check("a_overflow_clear", 32'(bus_a.overflow), 32'd0);

    // 16 continuous pairs, some clamped; frame_done positions checked by the scoreboard.
    for (int i = 1; i <= 16; i++) begin
      qa.push_back((i % 4 == 1) ? 32'd0 : fbits(i + 1));
      drive_a(1'b1, (i % 4 == 1) ? (fbits(i) | 32'h80000000) : fbits(i), 1'b1, fbits(1));
    end
    drain_a();
    check("a_throughput_run", 32'(max_run_a), 32'd16);

    // Reset with words queued and a pair inside the adder.
    for (int i = 1; i <= 3; i++) drive_a(1'b0, 32'd0, 1'b1, fbits(i));
    for (int i = 1; i <= 3; i++) drive_a(1'b1, fbits(i), 1'b1, fbits(i + 3));
    bus_a.valid_main = 1'b0;
    bus_a.valid_skip = 1'b0;
    #2 rst_a = 1'b1;
    #1;
    check("a_rst_async_pxl", bus_a.pxl_out, 32'd0);
    check("a_rst_async_valid", 32'(bus_a.valid_out), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_a = 1'b0;
    idle_a(10);
    check("a_post_rst_valid", 32'(bus_a.valid_out), 32'd0);
    check("a_post_rst_pxl", bus_a.pxl_out, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      qa.push_back(fbits(i + 2));
      drive_a(1'b1, fbits(i), 1'b1, fbits(2));
    end
    drain_a();

    // Overflow on DUT B: 5 skip words into a 4-deep FIFO, then 4 main words.
    for (int k = 1; k <= 5; k++) drive_b(1'b0, 32'd0, 1'b1, fbits(k));
    idle_b(1);
    check("b_overflow_set", 32'(bus_b.overflow), 32'd1);
    idle_b(5);
    check("b_overflow_sticky", 32'(bus_b.overflow), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      qb.push_back(fbits(k + 1));
      drive_b(1'b1, fbits(1), 1'b0, 32'd0);
    end
    drain_b();
    drive_b(1'b1, fbits(1), 1'b0, 32'd0);
    idle_b(10);
    check("b_out_count", 32'(cnt_b), 32'd4);
    check("b_overflow_end", 32'(bus_b.overflow), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/residual_add_relu_sync.md
Name: residual_add_relu_sync

Overview:
- Output stage of every ResNet-50 bottleneck block (layer1–layer4): joins the main path (conv3 output) with the shortcut path (projection conv or identity), adds them in FP32, then applies ReLU.
- Replaces fixed-delay line-buffer alignment with FIFO handshake alignment, so the two branch latencies need not be known at build time.
- Output feeds the next bottleneck block's pxl_in / valid_in.

Parameters:
- DATA_WIDTH, 32, pixel width (IEEE-754 single precision).
- IMAGE_WIDTH, 64, output feature-map width.
- IMAGE_HEIGHT, 64, output feature-map height.
- CHANNEL_NUM, 1024, output channels per frame.
- FIFO_DEPTH, 16, entries per branch FIFO; power of 2, minimum 4.
- FRAME_SIZE, IMAGE_WIDTH*IMAGE_HEIGHT*CHANNEL_NUM, output pixels per frame.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-high reset.
- valid_main, input, 1, main-path pixel strobe.
- pxl_main, input, DATA_WIDTH, main-path pixel.
- valid_skip, input, 1, shortcut-path pixel strobe.
- pxl_skip, input, DATA_WIDTH, shortcut-path pixel.
- pxl_out, output, DATA_WIDTH, ReLU(main + skip).
- valid_out, output, 1, pxl_out strobe.
- frame_done, output, 1, one-cycle pulse coincident with the last output pixel of a frame.
- overflow, output, 1, sticky error: a write arrived while its FIFO was full.

Behaviour:
- Reset (async, active-high): clears both FIFO pointers and counts, pair register, ReLU register, and pixel counter. pxl_out=0, valid_out=0, frame_done=0, overflow=0.
- Two independent FIFOs, main and skip, each FIFO_DEPTH x DATA_WIDTH.
  - Write occurs when the valid strobe is high and the FIFO is not full.
  - Not first-word-fall-through: a word written at edge t is poppable at edge t+1 at the earliest.
- Pair issue: at each edge where both FIFOs are non-empty, pop one word from each into the pair register and assert the add strobe for one cycle. At most one pair per cycle.
- Simultaneous write and pop on the same FIFO is legal. Count is unchanged; a full FIFO with a concurrent pop still rejects the write (full is evaluated before the pop).
- Overflow: write to a full FIFO drops the word and sets overflow. overflow stays set until reset. Pairing continues on the remaining data.
- Add: the pair register drives the existing fp_add_sub (in_a=main, in_b=skip). Its valid_out and out feed the ReLU stage.
- ReLU stage is registered:
  - If the sum's bit[DATA_WIDTH-1] is 1, pxl_out=0 (-0.0, negative values and sign-set NaN all become +0).
  - Otherwise pxl_out equals the sum.
  - valid_out follows the adder valid by 1 cycle.
- Latency: from the edge where both FIFOs first hold a matching word to valid_out = 1 (pair register) + fp_add_sub latency + 1 (ReLU). Throughput is one pixel per cycle when both branches stream continuously.
- Ordering: strict FIFO order per branch; the k-th main pixel is always added to the k-th accepted skip pixel.
- Pixel counter: increments on each valid_out. At count FRAME_SIZE-1, frame_done pulses with that valid_out and the counter wraps to 0.
- Idle: pxl_out holds its last value while valid_out=0. frame_done is never high without valid_out.
- Reset mid-frame: all in-flight FIFO data and partial-frame count are discarded. The first pixel after reset is pixel 0 of a new frame.

Test Plan:
- Aligned stream: main 0x3FC00000 (1.5) and skip 0x40000000 (2.0) on the same cycle → pxl_out=0x40600000 (3.5), valid_out exactly fp_add_sub latency + 2 cycles later.
- Negative clamp: main 0xC0400000 (-3.0), skip 0x3F800000 (1.0) → pxl_out=0x00000000, valid_out=1. Also main 0x80000000, skip 0x00000000 → pxl_out=0x00000000.
- Skew: skip branch leads by 10 pixels with FIFO_DEPTH=16, skip values 1.0..10.0, main all 1.0 → outputs 2.0..11.0 in order, no overflow, no dropped pixels.
- Overflow: FIFO_DEPTH=4, push 5 skip words with no main → overflow=1 and stays 1. Then push 4 main words → exactly 4 outputs using the first 4 skip words.
- Frame boundary: IMAGE_WIDTH=2, IMAGE_HEIGHT=2, CHANNEL_NUM=2, 16 continuous pairs → frame_done high on output 8 and output 16 only.
- Reset mid-operation: assert reset with 3 words in each FIFO and a pair in flight → outputs go to 0 asynchronously, no valid_out after release until new pairs arrive, and the next frame_done comes after exactly FRAME_SIZE new outputs.
